// File: rtl/unidade_controle_mc.sv
// Multicycle processor control unit: Moore FSM sequencing fetch, decode, execute,
// memory access and write-back, with halt state and a sticky illegal-opcode flag.
module unidade_controle_mc #(
  parameter logic [5:0] OPC_HALT = 6'b111111,
  parameter logic [5:0] OPC_NOP  = 6'b000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       mem_pronta,
  input  logic       Zero,
  output logic [1:0] OpAlu,
  output logic       EscrevePC,
  output logic       EscreveIR,
  output logic       EscreveReg,
  output logic       LeMem,
  output logic       EscreveMem,
  output logic       IouD,
  output logic       MemParaReg,
  output logic       RegDst,
  output logic       OrigA,
  output logic [1:0] OrigB,
  output logic [1:0] OrigPC,
  output logic [3:0] estado,
  output logic       parado,
  output logic       erro_opcode
);

  localparam logic [5:0] OPC_LW   = 6'b000001;
  localparam logic [5:0] OPC_SW   = 6'b000010;
  localparam logic [5:0] OPC_BEQ  = 6'b000011;
  localparam logic [5:0] OPC_JMP  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b000110;

  typedef enum logic [3:0] {
    BUSCA       = 4'd0,
    DECODIFICA  = 4'd1,
    EXEC_ALU    = 4'd2,
    ESCRITA_ALU = 4'd3,
    EXEC_IMM    = 4'd4,
    ESCRITA_IMM = 4'd5,
    END_MEM     = 4'd6,
    LE_MEM      = 4'd7,
    ESCRITA_MEM = 4'd8,
    GRAVA_MEM   = 4'd9,
    DESVIO      = 4'd10,
    SALTO       = 4'd11,
    PARADO      = 4'd12
  } estado_t;

  // busca/desvio/salto mark the states whose PC/IR enables depend on live inputs
  typedef struct packed {
    logic       le_mem;
    logic       esc_mem;
    logic       iou_d;
    logic       mem_reg;
    logic       reg_dst;
    logic       esc_reg;
    logic       orig_a;
    logic [1:0] orig_b;
    logic [1:0] op_alu;
    logic [1:0] orig_pc;
    logic       busca;
    logic       desvio;
    logic       salto;
    logic       parado;
  } saida_t;

  estado_t est_q, est_d;
  saida_t  sai_q;
  logic    erro_q;
  logic    opc_ilegal;

  function automatic logic eh_alu(input logic [5:0] op);
    return (op == 6'b000101) || (op == 6'b000111) || (op == 6'b010110) ||
           ((op >= 6'b001011) && (op <= 6'b010011));
  endfunction

  function automatic saida_t saidas_de(input estado_t s);
    saida_t o;
    o = '0;
    case (s)
      BUSCA: begin
        o.le_mem = 1'b1;
        o.orig_b = 2'b01;
        o.busca  = 1'b1;
      end
      DECODIFICA: o.orig_b = 2'b10;
      EXEC_ALU: begin
        o.orig_a = 1'b1;
        o.op_alu = 2'b10;
      end
      ESCRITA_ALU: begin
        o.reg_dst = 1'b1;
        o.esc_reg = 1'b1;
      end
      EXEC_IMM, END_MEM: begin
        o.orig_a = 1'b1;
        o.orig_b = 2'b10;
      end
      ESCRITA_IMM: o.esc_reg = 1'b1;
      LE_MEM: begin
        o.le_mem = 1'b1;
        o.iou_d  = 1'b1;
      end
      ESCRITA_MEM: begin
        o.mem_reg = 1'b1;
        o.esc_reg = 1'b1;
      end
      GRAVA_MEM: begin
        o.esc_mem = 1'b1;
        o.iou_d   = 1'b1;
      end
      DESVIO: begin
        o.orig_a  = 1'b1;
        o.op_alu  = 2'b01;
        o.orig_pc = 2'b01;
        o.desvio  = 1'b1;
      end
      SALTO: begin
        o.orig_pc = 2'b10;
        o.salto   = 1'b1;
      end
      PARADO: o.parado = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Opcode is only looked at in DECODIFICA and END_MEM
  always_comb begin
    est_d      = BUSCA;
    opc_ilegal = 1'b0;
    case (est_q)
      BUSCA:       est_d = mem_pronta ? DECODIFICA : BUSCA;
      DECODIFICA: begin
        if (eh_alu(Opcode))                         est_d = EXEC_ALU;
        else if (Opcode == OPC_ADDI)                est_d = EXEC_IMM;
        else if (Opcode == OPC_LW || Opcode == OPC_SW) est_d = END_MEM;
        else if (Opcode == OPC_BEQ)                 est_d = DESVIO;
        else if (Opcode == OPC_JMP)                 est_d = SALTO;
        else if (Opcode == OPC_HALT)                est_d = PARADO;
        else if (Opcode == OPC_NOP)                 est_d = BUSCA;
        else begin
          est_d      = BUSCA;
          opc_ilegal = 1'b1;
        end
      end
      EXEC_ALU:    est_d = ESCRITA_ALU;
      EXEC_IMM:    est_d = ESCRITA_IMM;
      END_MEM: begin
        if (Opcode == OPC_LW)      est_d = LE_MEM;
        else if (Opcode == OPC_SW) est_d = GRAVA_MEM;
        else                       est_d = BUSCA;
      end
      LE_MEM:      est_d = mem_pronta ? ESCRITA_MEM : LE_MEM;
      GRAVA_MEM:   est_d = mem_pronta ? BUSCA : GRAVA_MEM;
      PARADO:      est_d = PARADO;
      default:     est_d = BUSCA;
    endcase
  end

  // Outputs are registered from the next state so they line up with estado
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      est_q  <= BUSCA;
      sai_q  <= saidas_de(BUSCA);
      erro_q <= 1'b0;
    end else begin
      est_q <= est_d;
      sai_q <= saidas_de(est_d);
      if (opc_ilegal) erro_q <= 1'b1;
    end
  end

  // Input-dependent enables are also gated by reset so they drop the instant it asserts
  assign EscreveIR   = reset & sai_q.busca & mem_pronta;
  assign EscrevePC   = reset & ((sai_q.busca & mem_pronta) | (sai_q.desvio & Zero) | sai_q.salto);
  assign EscreveReg  = sai_q.esc_reg;
  assign LeMem       = sai_q.le_mem;
  assign EscreveMem  = sai_q.esc_mem;
  assign IouD        = sai_q.iou_d;
  assign MemParaReg  = sai_q.mem_reg;
  assign RegDst      = sai_q.reg_dst;
  assign OrigA       = sai_q.orig_a;
  assign OrigB       = sai_q.orig_b;
  assign OrigPC      = sai_q.orig_pc;
  assign OpAlu       = sai_q.op_alu;
  assign estado      = est_q;
  assign parado      = sai_q.parado;
  assign erro_opcode = erro_q;

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Bench for unidade_controle_mc: directed scenarios with literal state sequences plus
// randomized instruction streams compared every cycle against an instruction-level model.
module tb_unidade_controle_mc;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       mem_pronta;
  logic       Zero;
  logic [1:0] OpAlu;
  logic       EscrevePC, EscreveIR, EscreveReg, LeMem, EscreveMem, IouD;
  logic       MemParaReg, RegDst, OrigA;
  logic [1:0] OrigB, OrigPC;
  logic [3:0] estado;
  logic       parado, erro_opcode;

  unidade_controle_mc dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .mem_pronta(mem_pronta), .Zero(Zero),
    .OpAlu(OpAlu), .EscrevePC(EscrevePC), .EscreveIR(EscreveIR), .EscreveReg(EscreveReg),
    .LeMem(LeMem), .EscreveMem(EscreveMem), .IouD(IouD), .MemParaReg(MemParaReg),
    .RegDst(RegDst), .OrigA(OrigA), .OrigB(OrigB), .OrigPC(OrigPC), .estado(estado),
    .parado(parado), .erro_opcode(erro_opcode)
  );

  always #5 clock = ~clock;

  localparam logic [5:0] LW = 6'b000001, SW = 6'b000010, BEQ = 6'b000011;
  localparam logic [5:0] JMP = 6'b000100, ADDI = 6'b000110, ADD = 6'b000101;

  int vectors = 0;
  int miscompares = 0;
  int m_st = 0;
  bit m_err = 0;
  int m_path[$];
  int halt_cyc = 0;
  logic [5:0] instr = ADD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] dut_outs();
    return {EscrevePC, EscreveIR, EscreveReg, LeMem, EscreveMem, IouD, MemParaReg,
            RegDst, OrigA, OrigB, OrigPC, OpAlu, parado, erro_opcode};
  endfunction

  function automatic bit is_alu(input logic [5:0] op);
    return (op == 6'b000101) || (op == 6'b000111) || (op == 6'b010110) ||
           (op >= 6'b001011 && op <= 6'b010011);
  endfunction

  // What each step of an instruction must drive on the datapath
  function automatic logic [16:0] exp_out(input int s, input bit mp, input bit z, input bit err);
    bit pc = 0, ir = 0, rg = 0, lm = 0, em = 0, io = 0, mr = 0, rd = 0, oa = 0, pd = 0;
    logic [1:0] ob = 0, opc = 0, alu = 0;
    case (s)
      0:  begin lm = 1; ob = 2'b01; pc = mp; ir = mp; end
      1:  ob = 2'b10;
      2:  begin oa = 1; alu = 2'b10; end
      3:  begin rd = 1; rg = 1; end
      4:  begin oa = 1; ob = 2'b10; end
      5:  rg = 1;
      6:  begin oa = 1; ob = 2'b10; end
      7:  begin lm = 1; io = 1; end
      8:  begin mr = 1; rg = 1; end
      9:  begin em = 1; io = 1; end
      10: begin oa = 1; alu = 2'b01; opc = 2'b01; pc = z; end
      11: begin opc = 2'b10; pc = 1; end
      12: pd = 1;
      default: ;
    endcase
    return {pc, ir, rg, lm, em, io, mr, rd, oa, ob, opc, alu, pd, err};
  endfunction

  // Instruction-level model: decode lays out the remaining steps as a list
  task automatic model_adv(input logic [5:0] op, input bit mp);
    if (m_st == 0 || m_st == 7 || m_st == 9) begin
      if (mp) m_st = (m_st == 0) ? 1 : (m_st == 7) ? 8 : 0;
    end else if (m_st == 12) begin
      m_st = 12;
    end else begin
      if (m_st == 1) begin
        m_path.delete();
        if (is_alu(op))                 m_path = '{2, 3};
        else if (op == ADDI)            m_path = '{4, 5};
        else if (op == LW || op == SW)  m_path = '{6};
        else if (op == BEQ)             m_path = '{10};
        else if (op == JMP)             m_path = '{11};
        else if (op == 6'b111111)       m_path = '{12};
        else if (op != 6'b000000)       m_err = 1;
      end else if (m_st == 6) begin
        if (op == LW)      m_path.push_back(7);
        else if (op == SW) m_path.push_back(9);
      end
      m_st = (m_path.size() > 0) ? m_path.pop_front() : 0;
    end
  endtask

  task automatic step(input logic [5:0] op, input bit mp, input bit z, input int exp_st);
    @(negedge clock);
    Opcode = op; mem_pronta = mp; Zero = z;
    #1;
    chk("estado", 32'(estado), 32'(m_st));
    if (exp_st >= 0) chk("estado_seq", 32'(estado), 32'(exp_st));
    chk("saidas", 32'(dut_outs()), 32'(exp_out(m_st, mp, z, m_err)));
    @(posedge clock);
    model_adv(op, mp);
  endtask

  // Asynchronous reset pulse entirely between two rising edges
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0; mem_pronta = 1'b1;
    #1;
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_saidas", 32'(dut_outs()), 32'h02040);
    m_st = 0; m_err = 0; m_path.delete();
    mem_pronta = 1'b0;
    #1 reset = 1'b1;
  endtask

  function automatic logic [5:0] pick();
    int r = $urandom_range(0, 19);
    logic [5:0] alus[4] = '{6'b000101, 6'b000111, 6'b010110, 6'b001011};
    if (r < 6) begin
      if (r == 5) return 6'($urandom_range(11, 19));
      return alus[r % 4];
    end
    case (r)
      6, 7:   return LW;
      8, 9:   return SW;
      10, 11: return BEQ;
      12:     return JMP;
      13, 14: return ADDI;
      15:     return 6'b000000;
      16:     return 6'b111111;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0; Opcode = 6'd0; mem_pronta = 1'b0; Zero = 1'b0;
    do_reset();

    // ALU instruction, memory always ready
    step(ADD, 1, 0, 0); step(ADD, 1, 0, 1); step(ADD, 1, 0, 2);
    step(ADD, 1, 0, 3); step(ADD, 1, 0, 0);

    // LW with three wait cycles; opcode noise while waiting must be ignored
    step(LW, 1, 0, 1); step(LW, 1, 0, 6);
    step(6'($urandom), 0, 0, 7); step(6'($urandom), 0, 0, 7); step(6'($urandom), 0, 0, 7);
    step(LW, 1, 0, 7); step(LW, 1, 0, 8); step(LW, 1, 0, 0);

    // BEQ taken then not taken
    step(BEQ, 1, 1, 1);
    #1 chk("beq1_pc", 32'({EscrevePC, OrigPC, OpAlu}), 32'b1_01_01);
    step(BEQ, 1, 1, 10); step(BEQ, 1, 0, 0); step(BEQ, 1, 0, 1);
    #1 chk("beq0_pc", 32'(EscrevePC), 32'd0);
    step(BEQ, 1, 0, 10);

    // Illegal opcode sets the sticky flag
    step(6'b111000, 1, 0, 0); step(6'b111000, 1, 0, 1); step(ADDI, 1, 0, 0);
    #1 chk("erro_set", 32'(erro_opcode), 32'd1);
    step(ADDI, 1, 0, 1); step(ADDI, 1, 0, 4); step(ADDI, 1, 0, 5); step(ADDI, 1, 0, 0);
    #1 chk("erro_sticky", 32'(erro_opcode), 32'd1);

    // Halt parks the FSM until reset
    step(6'b111111, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(6'($urandom), 1, 1, 12);
    do_reset();
    chk("halt_parado", 32'(parado), 32'd0);

    // Reset in the middle of a store wait
    step(SW, 1, 0, 0); step(SW, 1, 0, 1); step(SW, 1, 0, 6);
    step(SW, 0, 0, 9); step(SW, 0, 0, 9); step(SW, 0, 0, 9);
    do_reset();
    chk("sw_rst_escmem", 32'(EscreveMem), 32'd0);

    // Randomized instruction stream
    for (int c = 0; c < 4000; c++) begin
      logic [5:0] op;
      if (m_st == 0) instr = pick();
      if (m_st == 12) begin
        halt_cyc++;
        if (halt_cyc > 4) begin
          halt_cyc = 0;
          do_reset();
          continue;
        end
      end else if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      op = (m_st == 1 || m_st == 6) ? instr : 6'($urandom);
      step(op, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
